// File: rtl/alu_pipe.sv
// alu_pipe: pipelined WIDTH-bit ALU with valid/ready handshakes on both sides,
// full status flags and an iterative shift-add multiplier.
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       opcode_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             set_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             illegal_o,
    output logic             busy_o
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b0010;
    localparam logic [3:0] OP_SRL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_ABS = 4'b0110;
    localparam logic [3:0] OP_SEQ = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1011;

    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t state;
    state_t next_state;

    logic             accept;
    logic             is_mul;
    logic [SHW-1:0]   sh;

    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] alu_result;
    logic             alu_set;
    logic             alu_carry;
    logic             alu_overflow;
    logic             alu_illegal;
    logic             alu_zero;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     count;
    logic               last_step;

    // Upstream may only hand over work when idle and the output slot is free
    // (or being emptied this cycle); never during reset.
    assign ready_o = (state == IDLE) && (!valid_o || ready_i) && !rst_i;
    assign accept  = valid_i && ready_o;
    assign is_mul  = (MUL_EN != 0) && (opcode_i == OP_MUL);
    assign sh      = rt_i[SHW-1:0];

    // Single-cycle result and flags for every opcode except a live multiply.
    always_comb begin
        alu_result   = '0;
        alu_set      = 1'b0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        alu_illegal  = 1'b0;
        add_full     = {1'b0, rs_i} + {1'b0, rt_i};
        sub_full     = {1'b0, rs_i} - {1'b0, rt_i};
        case (opcode_i)
            OP_AND: alu_result = rs_i & rt_i;
            OP_ADD: begin
                alu_result   = add_full[WIDTH-1:0];
                alu_carry    = add_full[WIDTH];
                alu_overflow = (rs_i[WIDTH-1] == rt_i[WIDTH-1]) &&
                               (add_full[WIDTH-1] != rs_i[WIDTH-1]);
            end
            OP_SLL: alu_result = rs_i << sh;
            OP_SRL: alu_result = rs_i >> sh;
            OP_SUB: begin
                alu_result   = sub_full[WIDTH-1:0];
                alu_carry    = sub_full[WIDTH];
                alu_overflow = (rs_i[WIDTH-1] != rt_i[WIDTH-1]) &&
                               (sub_full[WIDTH-1] != rs_i[WIDTH-1]);
            end
            OP_SLT: begin
                alu_set    = $signed(rs_i) < $signed(rt_i);
                alu_result = {{(WIDTH-1){1'b0}}, alu_set};
            end
            OP_ABS: begin
                alu_result   = rs_i[WIDTH-1] ? (ZERO - rs_i) : rs_i;
                alu_overflow = (rs_i == MIN_NEG);
            end
            OP_SEQ: begin
                alu_set    = (rs_i == rt_i);
                alu_result = {{(WIDTH-1){1'b0}}, alu_set};
            end
            OP_OR:  alu_result = rs_i | rt_i;
            OP_XOR: alu_result = rs_i ^ rt_i;
            OP_SRA: alu_result = $signed(rs_i) >>> sh;
            OP_MUL: alu_illegal = (MUL_EN == 0);
            default: alu_illegal = 1'b1;
        endcase
        alu_zero = (alu_result == ZERO);
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    always_comb begin
        acc_next  = mplier[0] ? (acc + mcand) : acc;
        last_step = (count == SHW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: enter MUL on an accepted multiply, leave after the last bit.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept && is_mul) next_state = MUL;
            MUL:  if (last_step) next_state = IDLE;
        endcase
    end

    // Output registers and multiplier datapath; outputs only change when a new
    // result is registered, so a stalled result holds steady.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o    <= 1'b0;
            result_o   <= '0;
            set_o      <= 1'b0;
            zero_o     <= 1'b0;
            carry_o    <= 1'b0;
            overflow_o <= 1'b0;
            illegal_o  <= 1'b0;
            busy_o     <= 1'b0;
            mcand      <= '0;
            acc        <= '0;
            mplier     <= '0;
            count      <= '0;
        end else if (accept && !is_mul) begin
            valid_o    <= 1'b1;
            result_o   <= alu_result;
            set_o      <= alu_set;
            zero_o     <= alu_zero;
            carry_o    <= alu_carry;
            overflow_o <= alu_overflow;
            illegal_o  <= alu_illegal;
        end else if (accept && is_mul) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b1;
            mcand   <= {{WIDTH{1'b0}}, rs_i};
            mplier  <= rt_i;
            acc     <= '0;
            count   <= '0;
        end else if (state == MUL) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_next;
            count  <= count + SHW'(1);
            if (last_step) begin
                valid_o    <= 1'b1;
                busy_o     <= 1'b0;
                result_o   <= acc_next[WIDTH-1:0];
                carry_o    <= |acc_next[2*WIDTH-1:WIDTH];
                zero_o     <= (acc_next[WIDTH-1:0] == ZERO);
                set_o      <= 1'b0;
                overflow_o <= 1'b0;
                illegal_o  <= 1'b0;
            end
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized and directed scoreboard bench for alu_pipe (WIDTH=8).
module tb_alu_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic         ready_o;
    logic [3:0]   opcode_i;
    logic [W-1:0] rs_i;
    logic [W-1:0] rt_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] result_o;
    logic         set_o;
    logic         zero_o;
    logic         carry_o;
    logic         overflow_o;
    logic         illegal_o;
    logic         busy_o;

    typedef struct {
        logic [7:0] result;
        logic       set;
        logic       zero;
        logic       carry;
        logic       ovf;
        logic       illegal;
    } exp_t;

    exp_t exp_q[$];
    exp_t front;
    int   checks   = 0;
    int   failures = 0;
    bit   rand_done;

    alu_pipe #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .opcode_i(opcode_i), .rs_i(rs_i), .rt_i(rt_i), .valid_o(valid_o),
        .ready_i(ready_i), .result_o(result_o), .set_o(set_o), .zero_o(zero_o),
        .carry_o(carry_o), .overflow_o(overflow_o), .illegal_o(illegal_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the opcode definitions.
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int sa, sb, sh, r;
        e = '{result: 8'h00, set: 1'b0, zero: 1'b0, carry: 1'b0, ovf: 1'b0, illegal: 1'b0};
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = b % 8;
        r  = 0;
        case (op)
            0:  r = a & b;
            1:  begin r = a + b; e.carry = (r > 255); e.ovf = (sa + sb > 127) || (sa + sb < -128); end
            2:  r = a << sh;
            3:  r = a >> sh;
            4:  begin r = a - b; e.carry = (a < b); e.ovf = (sa - sb > 127) || (sa - sb < -128); end
            5:  begin e.set = (sa < sb); r = e.set ? 1 : 0; end
            6:  begin r = (sa < 0) ? -sa : sa; e.ovf = (r > 127); end
            7:  begin e.set = (a == b); r = e.set ? 1 : 0; end
            8:  r = a | b;
            9:  r = a ^ b;
            10: r = sa >>> sh;
            11: begin r = a * b; e.carry = (r > 255); end
            default: begin r = 0; e.illegal = 1'b1; end
        endcase
        e.result = 8'(r & 255);
        e.zero   = (e.result == 8'h00);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one operation (called just after a rising edge); waits bounded
    // for acceptance and records the expected response on acceptance.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int waited = 0;
        valid_i  = 1'b1;
        opcode_i = op;
        rs_i     = a;
        rt_i     = b;
        @(negedge clk);
        while (!ready_o && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!ready_o) begin
            failures++;
            $display("[TB] FAIL accept_timeout: ready_o stayed %0b, expected 1 within 64 cycles", ready_o);
        end else begin
            exp_q.push_back(model(int'(op), int'(a), int'(b)));
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, 32'(valid_o), 32'd0);
        checkOutput({tag, "_result"}, 32'(result_o), 32'd0);
        checkOutput({tag, "_flags"}, 32'({set_o, zero_o, carry_o, overflow_o, illegal_o, busy_o}), 32'd0);
        checkOutput({tag, "_ready"}, 32'(ready_o), 32'd0);
    endtask

    // Monitor: every presented result is compared to the oldest expected
    // entry (also while stalled); the entry retires on the handshake.
    always @(negedge clk) begin
        if (!rst_i && valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_result: valid_o=1 result %0h, expected no pending result", result_o);
            end else begin
                front = exp_q[0];
                checkOutput("res_result", 32'(result_o), 32'(front.result));
                checkOutput("res_set", 32'(set_o), 32'(front.set));
                checkOutput("res_zero", 32'(zero_o), 32'(front.zero));
                checkOutput("res_carry", 32'(carry_o), 32'(front.carry));
                checkOutput("res_overflow", 32'(overflow_o), 32'(front.ovf));
                checkOutput("res_illegal", 32'(illegal_o), 32'(front.illegal));
                if (ready_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        opcode_i = 4'h0; rs_i = '0; rt_i = '0;
        @(negedge clk);
        checkAllZero("reset");
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_ready", 32'(ready_o), 32'd1);
        tick();

        // Reset pulse mid-stream drops an in-flight result.
        applyStimulus(4'b0001, 8'h33, 8'h44);
        rst_i = 1'b1;
        exp_q.delete();
        tick();
        @(negedge clk);
        checkAllZero("midreset");
        tick();
        rst_i = 1'b0;

        applyStimulus(4'b0001, 8'hF0, 8'h20);
        @(negedge clk);
        checkOutput("add_latency", 32'(valid_o), 32'd1);
        checkOutput("add_result", 32'(result_o), 32'h10);
        checkOutput("add_carry", 32'(carry_o), 32'd1);
        tick();

        applyStimulus(4'b0100, 8'h80, 8'h01);
        applyStimulus(4'b0110, 8'h80, 8'h00);
        applyStimulus(4'b0101, 8'hFF, 8'h01);
        applyStimulus(4'b1010, 8'h90, 8'h0A);
        applyStimulus(4'b0010, 8'h81, 8'h01);
        applyStimulus(4'b0011, 8'h81, 8'h07);
        applyStimulus(4'b1110, 8'h12, 8'h34);
        applyStimulus(4'b0111, 8'h5A, 8'h5A);
        waitDrain();

        // Multiply: busy and stalled for exactly WIDTH cycles.
        applyStimulus(4'b1011, 8'h10, 8'h11);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            checkOutput("mul_busy", 32'(busy_o), 32'd1);
            checkOutput("mul_ready", 32'(ready_o), 32'd0);
            checkOutput("mul_no_valid", 32'(valid_o), 32'd0);
        end
        @(negedge clk);
        checkOutput("mul_valid", 32'(valid_o), 32'd1);
        checkOutput("mul_result", 32'(result_o), 32'h10);
        checkOutput("mul_carry", 32'(carry_o), 32'd1);
        checkOutput("mul_busy_done", 32'(busy_o), 32'd0);
        tick();
        applyStimulus(4'b1011, 8'h03, 8'h05);
        waitDrain();

        // Back-pressure: three ADDs while downstream stalls four cycles.
        ready_i = 1'b0;
        fork
            begin
                applyStimulus(4'b0001, 8'h01, 8'h02);
                applyStimulus(4'b0001, 8'h7F, 8'h01);
                applyStimulus(4'b0001, 8'hFF, 8'h01);
            end
            begin
                @(posedge clk);
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("stall_ready", 32'(ready_o), 32'd0);
                end
                tick();
                ready_i = 1'b1;
            end
        join
        waitDrain();

        // Reset at cycle 3 of a multiply aborts it.
        applyStimulus(4'b1011, 8'h07, 8'h09);
        tick();
        tick();
        rst_i = 1'b1;
        void'(exp_q.pop_back());
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        checkOutput("abort_ready", 32'(ready_o), 32'd1);
        checkOutput("abort_busy", 32'(busy_o), 32'd0);
        repeat (10) begin
            @(negedge clk);
            checkOutput("abort_no_valid", 32'(valid_o), 32'd0);
        end
        tick();

        // Randomized traffic with random downstream stalls.
        rand_done = 1'b0;
        fork
            begin
                repeat (300) applyStimulus(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    tick();
                    ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready_i = 1'b1;
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
